// File: rtl/mem_scan.sv
// mem_scan: walks every cell of the checkerboard state RAM in address order,
// presents each cell on a valid/ready stream and tallies empty/black/white
// cells, flagging any cell that holds the invalid code 11.
module mem_scan #(
  parameter int RD_LATENCY = 1,
  parameter int CELLS      = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [5:0] ram_addr,
  input  logic [1:0] ram_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [5:0] out_addr,
  output logic [1:0] out_data,
  output logic [6:0] cnt_empty,
  output logic [6:0] cnt_black,
  output logic [6:0] cnt_white,
  output logic       err,
  output logic       done
);

  typedef enum logic [2:0] {IDLE, ADDR, WAIT, OUT, DONE} state_t;

  localparam logic [5:0] LAST = 6'(CELLS - 1);

  state_t     state;
  logic [5:0] idx;
  logic       hs;

  // The cell index is the RAM address during ADDR/WAIT and the presented
  // address during OUT; it only moves on a handshake, so both stay stable.
  assign ram_addr = idx;
  assign out_addr = idx;
  assign hs       = out_valid && out_ready;

  // Scan FSM; counts update on every handshake, including one that lands in
  // the same cycle as an abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      cnt_empty <= '0;
      cnt_black <= '0;
      cnt_white <= '0;
    end else begin
      if (hs) begin
        case (out_data)
          2'b00:   cnt_empty <= cnt_empty + 7'd1;
          2'b01:   cnt_black <= cnt_black + 7'd1;
          2'b10:   cnt_white <= cnt_white + 7'd1;
          default: err       <= 1'b1;
        endcase
      end
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (en) begin
            cnt_empty <= '0;
            cnt_black <= '0;
            cnt_white <= '0;
            err       <= 1'b0;
            idx       <= '0;
            state     <= ADDR;
          end
        end
        ADDR: begin
          if (!en) begin
            state <= IDLE;
          end else if (RD_LATENCY == 0) begin
            out_data  <= ram_data;
            out_valid <= 1'b1;
            state     <= OUT;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (!en) begin
            state <= IDLE;
          end else begin
            out_data  <= ram_data;
            out_valid <= 1'b1;
            state     <= OUT;
          end
        end
        OUT: begin
          if (!en) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            if (idx == LAST) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              idx   <= idx + 6'd1;
              state <= ADDR;
            end
          end
        end
        DONE: begin
          if (!en) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_scan.sv
`timescale 1ns/1ps
// Bench for mem_scan: a registered-read instance (dut) and a combinational-read
// instance (dut0) share one RAM image; expected cells are queued from the RAM
// image when a scan starts and popped on each handshake.
module tb_mem_scan;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, en0, out_ready, ready0;
  logic [1:0] mem [64];
  logic [5:0] ram_addr, ram_addr0, out_addr, out_addr0;
  logic [1:0] ram_data, ram_data0, out_data, out_data0;
  logic       out_valid, out_valid0, err, err0, done, done0;
  logic [6:0] ce, cb, cw, ce0, cb0, cw0;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct packed {logic [5:0] a; logic [1:0] d;} cell_t;
  cell_t exp_q[$];

  // registered-read RAM for dut, combinational for dut0
  always @(posedge clk) ram_data <= mem[ram_addr];
  assign ram_data0 = mem[ram_addr0];

  mem_scan #(.RD_LATENCY(1), .CELLS(64)) dut (
    .clk(clk), .rst(rst), .en(en), .ram_addr(ram_addr), .ram_data(ram_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_data(out_data), .cnt_empty(ce), .cnt_black(cb), .cnt_white(cw),
    .err(err), .done(done));

  mem_scan #(.RD_LATENCY(0), .CELLS(64)) dut0 (
    .clk(clk), .rst(rst), .en(en0), .ram_addr(ram_addr0), .ram_data(ram_data0),
    .out_valid(out_valid0), .out_ready(ready0), .out_addr(out_addr0),
    .out_data(out_data0), .cnt_empty(ce0), .cnt_black(cb0), .cnt_white(cw0),
    .err(err0), .done(done0));

  task automatic mem_reset();
    for (int i = 0; i < 64; i++) mem[i] = 2'b00;
  endtask

  task automatic mem_checker();
    for (int i = 0; i < 64; i++) mem[i] = (i % 2 == 0) ? 2'b01 : 2'b10;
  endtask

  // Drives one full scan on dut, checking every cell against the queue.
  task automatic run_scan(input bit rnd, input int exp_lat);
    int cyc, hs_cnt, done_at, xe, xb, xw;
    bit stall, xerr;
    cell_t prev, e;
    exp_q.delete();
    xe = 0; xb = 0; xw = 0; xerr = 0;
    for (int i = 0; i < 64; i++) begin
      exp_q.push_back({6'(i), mem[i]});
      case (mem[i])
        2'b00: xe++;
        2'b01: xb++;
        2'b10: xw++;
        default: xerr = 1;
      endcase
    end
    @(negedge clk);
    en = 1'b1;
    out_ready = 1'b1;
    cyc = 0; hs_cnt = 0; done_at = -1; stall = 0; prev = '0;
    while (done_at < 0 && cyc < 6000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        n_chk++;
        if ({ce, cb, cw, err} !== 22'd0) begin
          n_fail++;
          $display("FAIL scan_clear: got e=%0d b=%0d w=%0d err=%b expected all 0", ce, cb, cw, err);
        end
      end
      if (stall) begin
        n_chk++;
        if (!out_valid || {out_addr, out_data} !== prev) begin
          n_fail++;
          $display("FAIL stall_stable: got v=%b addr=%0d data=%b expected v=1 addr=%0d data=%b",
                   out_valid, out_addr, out_data, prev.a, prev.d);
        end
      end
      if (done) done_at = cyc - 1;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && out_ready) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL extra_cell: got addr %0d expected no more cells", out_addr);
        end else begin
          e = exp_q.pop_front();
          if ({out_addr, out_data} !== e) begin
            n_fail++;
            $display("FAIL cell: got addr %0d data %b expected addr %0d data %b",
                     out_addr, out_data, e.a, e.d);
          end
        end
        hs_cnt++;
      end
      stall = out_valid && !out_ready;
      prev = {out_addr, out_data};
    end
    n_chk++;
    if (done_at < 0) begin
      n_fail++;
      $display("FAIL scan_timeout: got no done after %0d cycles expected done", cyc);
    end else if (!rnd && done_at != exp_lat) begin
      n_fail++;
      $display("FAIL scan_latency: got %0d cycles expected %0d", done_at, exp_lat);
    end
    n_chk++;
    if (hs_cnt != 64 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL cell_count: got %0d cells (%0d left) expected 64", hs_cnt, exp_q.size());
    end
    n_chk++;
    if (ce !== 7'(xe) || cb !== 7'(xb) || cw !== 7'(xw) || err !== xerr) begin
      n_fail++;
      $display("FAIL counts: got e=%0d b=%0d w=%0d err=%b expected e=%0d b=%0d w=%0d err=%b",
               ce, cb, cw, err, xe, xb, xw, xerr);
    end
  endtask

  task automatic end_scan();
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    n_chk++;
    if (done !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL done_drop: got done=%b valid=%b expected 0 0", done, out_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; en0 = 1'b0; out_ready = 1'b0; ready0 = 1'b0;
    mem_reset();
    repeat (3) @(negedge clk);
    n_chk++;
    if ({ram_addr, out_addr, out_data, out_valid, done, err, ce, cb, cw} !== 38'd0 ||
        {ram_addr0, out_addr0, out_data0, out_valid0, done0, err0, ce0, cb0, cw0} !== 38'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %h / %h expected 0 / 0",
               {ram_addr, out_addr, out_data, out_valid, done, err, ce, cb, cw},
               {ram_addr0, out_addr0, out_data0, out_valid0, done0, err0, ce0, cb0, cw0});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_all_zero();
    mem_reset();
    run_scan(1'b0, 192);
    repeat (10) @(negedge clk);
    n_chk++;
    if (done !== 1'b1 || out_valid !== 1'b0 || ce !== 7'd64) begin
      n_fail++;
      $display("FAIL hold_done: got done=%b valid=%b e=%0d expected 1 0 64", done, out_valid, ce);
    end
    end_scan();
  endtask

  task automatic test_pattern();
    mem_checker();
    run_scan(1'b0, 192);
    end_scan();
  endtask

  task automatic test_stall();
    mem_checker();
    run_scan(1'b1, 0);
    end_scan();
  endtask

  task automatic test_err();
    mem_reset();
    mem[17] = 2'b11;
    run_scan(1'b0, 192);
    n_chk++;
    if (err !== 1'b1 || ce !== 7'd63 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL err_cell: got err=%b e=%0d done=%b expected 1 63 1", err, ce, done);
    end
    end_scan();
  endtask

  task automatic test_abort();
    int cyc, nxt;
    bit hit;
    mem_checker();
    @(negedge clk);
    en = 1'b1; out_ready = 1'b1;
    cyc = 0; nxt = 0; hit = 0;
    while (!hit && cyc < 500) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        n_chk++;
        if (out_addr !== 6'(nxt)) begin
          n_fail++;
          $display("FAIL abort_order: got addr %0d expected %0d", out_addr, nxt);
        end
        nxt++;
        if (out_addr == 6'd20) begin
          en = 1'b0;
          hit = 1;
        end
      end
    end
    n_chk++;
    if (!hit) begin
      n_fail++;
      $display("FAIL abort_timeout: got no cell 20 after %0d cycles expected cell 20", cyc);
    end
    @(negedge clk);
    n_chk++;
    if (out_valid !== 1'b0 || done !== 1'b0 || ce !== 7'd0 || cb !== 7'd11 || cw !== 7'd10) begin
      n_fail++;
      $display("FAIL abort_state: got v=%b done=%b e=%0d b=%0d w=%0d expected 0 0 0 11 10",
               out_valid, done, ce, cb, cw);
    end
    repeat (3) @(negedge clk);
    n_chk++;
    if (out_valid !== 1'b0 || cb !== 7'd11) begin
      n_fail++;
      $display("FAIL abort_idle: got v=%b b=%0d expected 0 11", out_valid, cb);
    end
    run_scan(1'b0, 192);
    end_scan();
  endtask

  task automatic test_rst_mid();
    int cyc;
    mem_checker();
    @(negedge clk);
    en = 1'b1; out_ready = 1'b1; cyc = 0;
    while (!(out_valid && out_addr == 6'd5) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    n_chk++;
    if (!(out_valid && cb == 7'd3 && cw == 7'd2)) begin
      n_fail++;
      $display("FAIL rst_setup: got v=%b b=%0d w=%0d expected 1 3 2", out_valid, cb, cw);
    end
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if ({ram_addr, out_addr, out_data, out_valid, done, err, ce, cb, cw} !== 38'd0) begin
      n_fail++;
      $display("FAIL async_rst: got %h expected 0",
               {ram_addr, out_addr, out_data, out_valid, done, err, ce, cb, cw});
    end
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_scan(1'b0, 192);
    end_scan();
  endtask

  task automatic test_lat0();
    int cyc, nxt, done_at;
    mem_reset();
    @(negedge clk);
    en0 = 1'b1; ready0 = 1'b1;
    cyc = 0; nxt = 0; done_at = -1;
    while (done_at < 0 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (done0) done_at = cyc - 1;
      if (out_valid0) begin
        n_chk++;
        if (out_addr0 !== 6'(nxt) || out_data0 !== 2'b00) begin
          n_fail++;
          $display("FAIL lat0_cell: got addr %0d data %b expected addr %0d data 00",
                   out_addr0, out_data0, nxt);
        end
        nxt++;
      end
    end
    n_chk++;
    if (done_at != 128 || nxt != 64) begin
      n_fail++;
      $display("FAIL lat0_latency: got %0d cycles %0d cells expected 128 cycles 64 cells", done_at, nxt);
    end
    n_chk++;
    if (ce0 !== 7'd64 || cb0 !== 7'd0 || cw0 !== 7'd0 || err0 !== 1'b0) begin
      n_fail++;
      $display("FAIL lat0_counts: got e=%0d b=%0d w=%0d err=%b expected 64 0 0 0", ce0, cb0, cw0, err0);
    end
    @(negedge clk);
    en0 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_pattern();
    test_stall();
    test_err();
    test_abort();
    test_rst_mid();
    test_lat0();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_scan.md
MEM_SCAN -- requirements
Module: mem_scan

Interface
REQ-001 Parameter: RD_LATENCY, default 1, RAM read latency in clock cycles; legal values 0 (combinational read) and 1 (registered read).
REQ-002 Parameter: CELLS, default 64, number of board cells scanned; address width is fixed at 6.
REQ-003 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous and active-high.
REQ-005 Port: en  input  1  level enable; scan runs while high; scan aborts when low.
REQ-006 Port: ram_addr  output  6  read address to checkerboard_state_ram read port.
REQ-007 Port: ram_data  input  2  read data from RAM, valid RD_LATENCY cycles after ram_addr.
REQ-008 Port: out_valid  output  1  cell stream valid.
REQ-009 Port: out_ready  input  1  cell stream ready from consumer.
REQ-010 Port: out_addr  output  6  address of the presented cell.
REQ-011 Port: out_data  output  2  cell state: 00 empty, 01 black, 10 white, 11 invalid.
REQ-012 Port: cnt_empty, cnt_black, cnt_white  output  7 each  cell counts of the current or last scan, range 0..64.
REQ-013 Port: err  output  1  set if any scanned cell read 11 in the current or last scan.
REQ-014 Port: done  output  1  level; high while the scan has completed and en is still high.

Function
REQ-015 States: IDLE, ADDR, WAIT, OUT, DONE; WAIT is entered only when RD_LATENCY=1.
REQ-016 IDLE: when en=1, clear cnt_* and err, load index to 0, go to ADDR.
REQ-017 ADDR: drive ram_addr=index for one cycle; RD_LATENCY=0 -> capture ram_data into out_data and go to OUT; RD_LATENCY=1 -> go to WAIT.
REQ-018 WAIT: hold ram_addr; capture ram_data into out_data; go to OUT.
REQ-019 OUT: out_valid=1 with out_addr=index; out_addr and out_data stay stable until out_valid&&out_ready.
REQ-020 Handshake in OUT: add 1 to the matching count, or set err for 11; if index=CELLS-1, go to DONE; else increment index and go to ADDR.
REQ-021 out_valid is asserted only in OUT and drops the cycle after the handshake.
REQ-022 Throughput with out_ready held at 1: one cell per (2+RD_LATENCY) cycles; full scan takes 64*(2+RD_LATENCY) cycles from leaving IDLE to entering DONE.
REQ-023 DONE: done=1, out_valid=0; remain in DONE while en=1; go to IDLE when en=0; counts and err hold their values.
REQ-024 Abort: en=0 in ADDR, WAIT or OUT -> go to IDLE next cycle; out_valid=0; done stays 0; counts keep their partial values; a handshake in the same cycle is still counted.
REQ-025 A re-scan requires en to pass through 0; keeping en at 1 never restarts the scan.
REQ-026 Counts never wrap: at completion, cnt_empty+cnt_black+cnt_white plus the number of invalid cells equals 64.
REQ-027 Index increments by one per cell; 63 is the final cell and no wrap to 0 occurs within a scan.
REQ-028 When out_valid=0, out_ready is ignored.

Reset
REQ-029 On rst=1, asynchronously: state=IDLE; ram_addr=0, out_addr=0, out_data=00, out_valid=0, done=0, err=0, all cnt_*=0.
REQ-030 rst asserted mid-scan discards all progress; the first scan after reset release starts at address 0 when en=1.

Verification
REQ-031 Scenario: RAM all zeros (written by mem_reset), en=1, out_ready=1 -> 64 cells with addresses 0..63 in order, cnt_empty=64, cnt_black=0, cnt_white=0, err=0, done high 192 cycles after start (RD_LATENCY=1).
REQ-032 Scenario: RAM[i]=01 for even i and 10 for odd i -> cnt_black=32, cnt_white=32, cnt_empty=0; each out_data matches the write pattern.
REQ-033 Scenario: out_ready toggled pseudo-randomly -> out_addr and out_data stay stable while stalled, no cell is dropped or duplicated, final counts match REQ-032.
REQ-034 Scenario: RAM[17]=11, all other cells 00 -> err=1, cnt_empty=63, done=1.
REQ-035 Scenario: en dropped at cell 20 -> IDLE the next cycle, done=0, out_valid=0; en reasserted -> counts clear and the scan restarts at address 0.
REQ-036 Scenario: rst pulsed during OUT -> all outputs zero immediately (asynchronous); RD_LATENCY=0 build repeats REQ-031 with done at 128 cycles.
